// File: rtl/mem_copy_dma_pkg.sv
// mem_dma_pkg: FSM encoding and default RAM geometry shared by the copy engine and the RAM instance.
package mem_dma_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;
   localparam int MEM_WIDTH_DEF = 12;
   localparam int ADDR_WIDTH_DEF = 12;
   localparam int PORT_COUNT_DEF = 2;
endpackage

// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: flat multiport RAM bus; master drives address/data/write, slave returns registered read data.
interface mem_copy_dma_if import mem_dma_pkg::*; #(
   parameter int MEM_WIDTH = MEM_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PORT_COUNT = PORT_COUNT_DEF
);
   logic [ADDR_WIDTH*PORT_COUNT-1:0] mem_address;
   logic [MEM_WIDTH*PORT_COUNT-1:0] mem_datain;
   logic [MEM_WIDTH*PORT_COUNT-1:0] mem_dataout;
   logic [PORT_COUNT-1:0] mem_write;
   modport master(output mem_address, output mem_datain, output mem_write, input mem_dataout);
   modport slave(input mem_address, input mem_datain, input mem_write, output mem_dataout);
endinterface

// File: rtl/mem_copy_dma_pack.sv
// mem_port_pack: places the read and write port signals into their flat-bus slices, zero elsewhere.
module mem_port_pack import mem_dma_pkg::*; #(
   parameter int MEM_WIDTH = MEM_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PORT_COUNT = PORT_COUNT_DEF,
   parameter int RD_PORT = 0,
   parameter int WR_PORT = 1
) (
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [MEM_WIDTH-1:0] wr_data,
   input  logic wr_en,
   output logic [ADDR_WIDTH*PORT_COUNT-1:0] address,
   output logic [MEM_WIDTH*PORT_COUNT-1:0] datain,
   output logic [PORT_COUNT-1:0] write
);
   always_comb begin
      address = '0;
      datain = '0;
      write = '0;
      address[RD_PORT*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr;
      address[WR_PORT*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr;
      datain[WR_PORT*MEM_WIDTH +: MEM_WIDTH] = wr_data;
      write[WR_PORT] = wr_en;
   end
endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: forward word copy through a read port and a write port, one word per cycle after a prime cycle.
// Define MEM_COPY_DMA_CHECKSUM_EN to add an XOR checksum of the written words.
module mem_copy_dma import mem_dma_pkg::*; #(
   parameter int MEM_WIDTH = MEM_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PORT_COUNT = PORT_COUNT_DEF,
   parameter int RD_PORT = 0,
   parameter int WR_PORT = 1
) (
   input  logic clk,
   input  logic reset,
   mem_copy_dma_if.master mem,
   input  logic start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   output logic busy,
   output logic done
`ifdef MEM_COPY_DMA_CHECKSUM_EN
  ,output logic [MEM_WIDTH-1:0] checksum
`endif
);
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rem_q, rem_d;
   logic [MEM_WIDTH-1:0] rd_data, wr_data;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic wr_en;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
   logic [MEM_WIDTH-1:0] chk_q, chk_d;
   assign checksum = chk_q;
`endif
   assign rd_data = mem.mem_dataout[RD_PORT*MEM_WIDTH +: MEM_WIDTH];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         rem_q <= '0;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
         chk_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rem_q <= rem_d;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
         chk_q <= chk_d;
`endif
      end
   end
   always_comb begin
      state_d = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rem_d = rem_q;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
      chk_d = chk_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            rd_ptr_d = src_addr;
            wr_ptr_d = dst_addr;
            rem_d = length;
            state_d = (length != '0) ? PRIME : DONE;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
            chk_d = '0;
`endif
         end
         PRIME: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d = STREAM;
         end
         STREAM: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
            state_d = (rem_q == ADDR_WIDTH'(1)) ? DONE : STREAM;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
            chk_d = chk_q ^ rd_data;
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   // Outputs decode from registered state only, so an async reset drops them at once.
   always_comb begin
      busy = (state_q == PRIME) || (state_q == STREAM);
      done = state_q == DONE;
      wr_en = state_q == STREAM;
      rd_addr = busy ? rd_ptr_q : '0;
      wr_addr = wr_en ? wr_ptr_q : '0;
      wr_data = wr_en ? rd_data : '0;
   end
   mem_port_pack #(
      .MEM_WIDTH(MEM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .PORT_COUNT(PORT_COUNT),
      .RD_PORT(RD_PORT), .WR_PORT(WR_PORT)
   ) u_pack (
      .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .address(mem.mem_address), .datain(mem.mem_datain), .write(mem.mem_write)
   );
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: scoreboard bench; stimulus queues expected writes and done events, a negedge monitor checks them.
module tb_mem_copy_dma;
   localparam int MW = 12, AW = 12, PC = 2, RD = 0, WR = 1;
   typedef struct {logic [AW-1:0] a; logic [MW-1:0] d;} wr_t;
   typedef struct {int at; int blen; logic [MW-1:0] ck;} dn_t;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [AW-1:0] src = '0, dst = '0, len = '0;
   logic busy, done;
   logic pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [MW-1:0] pl_data = '0;
   logic [MW-1:0] ram [0:(1<<AW)-1];
   logic [AW-1:0] wr_a;
   logic [MW-1:0] wr_d;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
   logic [MW-1:0] checksum;
`endif
   wr_t exp_wr[$];
   dn_t exp_dn[$];
   wr_t e;
   dn_t f;
   int ncyc = 0, brun = 0, pass_cnt = 0, tot = 0, st = 0;
   mem_copy_dma_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .PORT_COUNT(PC)) mif ();
   mem_copy_dma #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .PORT_COUNT(PC), .RD_PORT(RD), .WR_PORT(WR)) dut (
      .clk(clk), .reset(reset), .mem(mif), .start(start), .src_addr(src), .dst_addr(dst),
      .length(len), .busy(busy), .done(done)
`ifdef MEM_COPY_DMA_CHECKSUM_EN
     ,.checksum(checksum)
`endif
   );
   always #5 clk = ~clk;
   assign wr_a = mif.mem_address[WR*AW +: AW];
   assign wr_d = mif.mem_datain[WR*MW +: MW];
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      for (int p = 0; p < PC; p++) begin
         if (mif.mem_write[p]) ram[mif.mem_address[p*AW +: AW]] <= mif.mem_datain[p*MW +: MW];
         mif.mem_dataout[p*MW +: MW] <= ram[mif.mem_address[p*AW +: AW]];
      end
   end
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask
   always @(negedge clk) begin
      ncyc++;
      if (!reset) brun = 0;
      else begin
         if (mif.mem_write[RD]) chk("rd_port_write", mif.mem_write[RD], 1'b0);
         if (mif.mem_write[WR]) begin
            if (exp_wr.size() == 0) chk("unexpected_write", mif.mem_write[WR], 1'b0);
            else begin
               e = exp_wr.pop_front();
               chk("wr_addr", wr_a, e.a);
               chk("wr_data", wr_d, e.d);
            end
         end
         if (busy) brun++;
         if (done) begin
            if (exp_dn.size() == 0) chk("unexpected_done", done, 1'b0);
            else begin
               f = exp_dn.pop_front();
               chk("done_cycle", ncyc, f.at);
               chk("busy_len", brun, f.blen);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
               chk("checksum_at_done", checksum, f.ck);
`endif
            end
            brun = 0;
         end
      end
   end
   task automatic pl(input logic [AW-1:0] a, input logic [MW-1:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask
   task automatic push(input logic [AW-1:0] a, input logic [MW-1:0] d);
      exp_wr.push_back('{a: a, d: d});
   endtask
   task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                     input int off, input int bl, input logic [MW-1:0] ck, input bit pd);
      @(negedge clk);
      #1;
      src = s; dst = d; len = l; start = 1'b1;
      st = ncyc;
      if (pd) exp_dn.push_back('{at: st + off, blen: bl, ck: ck});
      @(posedge clk);
      #1;
      start = 1'b0;
      src = 'x; dst = 'x; len = 'x;
   endtask
   task automatic drain();
      for (int i = 0; i < 60 && (exp_dn.size() != 0 || exp_wr.size() != 0); i++) @(negedge clk);
      chk("drain_timeout", exp_dn.size() + exp_wr.size(), 0);
      repeat (2) @(negedge clk);
   endtask
   initial begin
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_write", mif.mem_write, '0);
      chk("rst_addr", mif.mem_address, '0);
      chk("rst_datain", mif.mem_datain, '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      // basic copy
      pl(12'h010, 12'h111); pl(12'h011, 12'h222); pl(12'h012, 12'h333); pl(12'h013, 12'h444);
      pl(12'h400, 12'h5A5);
      push(12'h100, 12'h111); push(12'h101, 12'h222); push(12'h102, 12'h333); push(12'h103, 12'h444);
      go(12'h010, 12'h100, 12'd4, 6, 5, 12'h444, 1'b1);
      drain();
      chk("ram_100", ram[12'h100], 12'h111);
      chk("ram_103", ram[12'h103], 12'h444);
      chk("src_010", ram[12'h010], 12'h111);
      chk("src_013", ram[12'h013], 12'h444);
      // zero length
      go(12'h020, 12'h200, 12'd0, 1, 0, 12'h000, 1'b1);
      drain();
      // wrap
      pl(12'hFFE, 12'h0A1); pl(12'hFFF, 12'h0B2); pl(12'h000, 12'h0C3); pl(12'h001, 12'h0D4);
      push(12'h7FE, 12'h0A1); push(12'h7FF, 12'h0B2); push(12'h800, 12'h0C3); push(12'h801, 12'h0D4);
      go(12'hFFE, 12'h7FE, 12'd4, 6, 5, 12'h004, 1'b1);
      drain();
      chk("ram_801", ram[12'h801], 12'h0D4);
      // start while busy is ignored
      for (int i = 0; i < 5; i++) pl(12'h030 + 12'(i), 12'h301 + 12'(i));
      for (int i = 0; i < 5; i++) push(12'h300 + 12'(i), 12'h301 + 12'(i));
      go(12'h030, 12'h300, 12'd5, 7, 6, 12'h301, 1'b1);
      @(negedge clk);
      go(12'h010, 12'h400, 12'd3, 0, 0, 12'h000, 1'b0);
      drain();
      chk("ignored_dst", ram[12'h400], 12'h5A5);
      // reset mid-transfer
      for (int i = 0; i < 6; i++) pl(12'h040 + 12'(i), 12'h411 + 12'(i));
      pl(12'h502, 12'h777);
      push(12'h500, 12'h411); push(12'h501, 12'h412);
      go(12'h040, 12'h500, 12'd6, 0, 0, 12'h000, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_write", mif.mem_write, '0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_addr", mif.mem_address, '0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
      chk("abort_checksum", checksum, '0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("abort_ram_501", ram[12'h501], 12'h412);
      chk("abort_ram_502", ram[12'h502], 12'h777);
      chk("abort_queue", exp_wr.size(), 0);
      push(12'h510, 12'h411); push(12'h511, 12'h412);
      go(12'h040, 12'h510, 12'd2, 4, 3, 12'h003, 1'b1);
      drain();
      // checksum hold and clear on restart
      pl(12'h060, 12'h00F); pl(12'h061, 12'h0F0); pl(12'h062, 12'hF00);
      push(12'h600, 12'h00F); push(12'h601, 12'h0F0); push(12'h602, 12'hF00);
      go(12'h060, 12'h600, 12'd3, 5, 4, 12'hFFF, 1'b1);
      drain();
      repeat (3) @(negedge clk);
      chk("ram_602", ram[12'h602], 12'hF00);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
      chk("checksum_held", checksum, 12'hFFF);
`endif
      push(12'h610, 12'h00F);
      go(12'h060, 12'h610, 12'd1, 3, 2, 12'h00F, 1'b1);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
      chk("checksum_cleared", checksum, 12'h000);
`endif
      drain();
      chk("scoreboard_empty", exp_wr.size() + exp_dn.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end
endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Initiator-side block that drives the shared multiport RAM's flat port buses: address, datain, mem_write and dataout.
- Copies `length` words from `src_addr` to `dst_addr`. It reads through port RD_PORT and writes through port WR_PORT in a one-word-per-cycle pipeline.
- Sits between the processor control unit and the RAM. It uses a start/busy/done handshake.

Parameters:
- MEM_WIDTH, 12, word width; must match the RAM.
- ADDR_WIDTH, 12, address width; addresses wrap modulo 2^ADDR_WIDTH.
- PORT_COUNT, 2, number of RAM ports on the flat buses; must be >= 2.
- RD_PORT, 0, port index used for reads.
- WR_PORT, 1, port index used for writes; must differ from RD_PORT.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word address.
- dst_addr  in  ADDR_WIDTH  first destination word address.
- length  in  ADDR_WIDTH  word count; 0 = no-op.
- busy  out  1  high from the cycle after an accepted start until the last write edge.
- done  out  1  one-cycle pulse on completion.
- mem_address  out  ADDR_WIDTH*PORT_COUNT  flat address bus to the RAM; port j occupies slice [(j+1)*ADDR_WIDTH-1 -: ADDR_WIDTH].
- mem_datain  out  MEM_WIDTH*PORT_COUNT  flat write-data bus; same slicing.
- mem_write  out  PORT_COUNT  per-port write enable.
- mem_dataout  in  MEM_WIDTH*PORT_COUNT  registered RAM read data, valid one edge after the address is presented.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0.
  - mem_address=0, mem_datain=0, mem_write=0.
  - Internal pointers and counter cleared.
- Ports other than RD_PORT and WR_PORT always drive address 0, data 0, write 0.
- FSM states: IDLE, PRIME, STREAM, DONE.
- IDLE:
  - Outputs idle; mem_write=0.
  - start=1 and length!=0: latch rd_ptr=src_addr, wr_ptr=dst_addr, remaining=length; go to PRIME.
  - start=1 and length==0: go to DONE; no RAM writes.
- PRIME:
  - busy=1; RD_PORT address = rd_ptr; mem_write=0.
  - At the edge: rd_ptr++; go to STREAM.
- STREAM:
  - busy=1.
  - WR_PORT: address = wr_ptr, datain = RD_PORT slice of mem_dataout, mem_write[WR_PORT]=1.
  - RD_PORT address = rd_ptr; the read is harmless when it is the final word.
  - At the edge: wr_ptr++, rd_ptr++, remaining--.
  - If remaining was 1, go to DONE; otherwise stay in STREAM.
- DONE:
  - busy=0, done=1 for exactly one cycle, mem_write=0.
  - Next state IDLE.
- Timing: a copy of L words occupies L+1 busy cycles. done is asserted in cycle L+2 after the start edge.
- Throughput: one word per cycle after the single prime cycle.
- start while busy or in DONE is ignored and not queued.
- Pointers wrap from 2^ADDR_WIDTH-1 to 0 within a transfer.
- Overlapping ranges:
  - dst<=src: correct forward-copy result.
  - dst>src and dst<src+L: forward word-by-word propagation; the RAM resolves port 0 before port 1 at each edge. This case is not a supported use.
- Reset mid-transfer:
  - All outputs return to reset values immediately; mem_write drops asynchronously.
  - Already-written words remain; no done pulse.
- Inputs src_addr, dst_addr and length may change freely after the accepting edge.

Optional Feature:
- Macro: MEM_COPY_DMA_CHECKSUM_EN.
- Defined:
  - Adds output port checksum, MEM_WIDTH bits: the XOR of every word written during the transfer.
  - Cleared to 0 on an accepted start and on reset.
  - Final and valid when done=1; held until the next accepted start.
  - Value is 0 for length 0.
- Undefined: no checksum port or register; all other behaviour identical.

Decomposition:
- Package mem_dma_pkg:
  - FSM state encoding: IDLE=2'd0, PRIME=2'd1, STREAM=2'd2, DONE=2'd3.
  - Default MEM_WIDTH, ADDR_WIDTH and PORT_COUNT constants shared with the RAM instance.
- Sub-module mem_port_pack:
  - Combinational packer that places the read-port and write-port signals into the flat buses at the RD_PORT and WR_PORT slices.
  - Zero-fills all other slices.

Test Plan:
- Basic copy: preload RAM[0x010..0x013]=0x111,0x222,0x333,0x444; start with src=0x010, dst=0x100, length=4 -> busy for 5 cycles; done pulse in cycle 6; RAM[0x100..0x103] matches the source; source unchanged.
- Zero length: start with length=0 -> no mem_write ever high; done pulses the cycle after the start edge; busy stays 0.
- Wrap: src=0xFFE, dst=0x7FE, length=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001; writes 0x7FE..0x801 in order.
- Start while busy: a second start mid-transfer with different arguments -> ignored; only the first copy happens; exactly one done pulse.
- Reset mid-transfer: reset=0 after 2 of 6 words written -> mem_write=0 within the same cycle; busy=0; no done; only words 0-1 written. A new copy after reset release succeeds.
- Checksum (MEM_COPY_DMA_CHECKSUM_EN defined): copy 0x00F, 0x0F0, 0xF00 -> checksum=0xFFF at done, held after done. A restart clears it to 0 on the accepting edge.
